// File: rtl/pong_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pong_pkg: state encoding and field constants shared with the renderer |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SERVE    = 3'd1,
        PLAY     = 3'd2,
        POINT    = 3'd3,
        GAMEOVER = 3'd4
    } pong_state_e;

    localparam int c_X_WIDTH     = 10;
    localparam int c_SCORE_WIDTH = 8;
    localparam int c_CENTER_X    = 285;
    localparam int c_LEFT_LIMIT  = 160;
    localparam int c_RIGHT_LIMIT = 430;
    localparam int c_WIN_SCORE   = 5;

endpackage
`default_nettype wire

// File: rtl/pong_game_engine_frame_countdown.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_countdown: 8-bit loadable per-frame down-counter, done strobe   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module frame_countdown (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] loadValue,
    output logic       done
);

    logic [7:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= 8'd0;
        end else if (load) begin
            r_count <= loadValue;
        end else if (tick && (r_count != 8'd0)) begin
            r_count <= r_count - 8'd1;
        end
    end

    // Fires on the tick that takes the count from 1 to 0.
    assign done = tick && !load && (r_count == 8'd1);

endmodule
`default_nettype wire

// File: rtl/pong_game_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pong_game_engine: per-frame ball position, scoring and match FSM      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module pong_game_engine
    import pong_pkg::*;
#(
    parameter int X_WIDTH      = c_X_WIDTH,
    parameter int SCORE_WIDTH  = c_SCORE_WIDTH,
    parameter int CENTER_X     = c_CENTER_X,
    parameter int LEFT_LIMIT   = c_LEFT_LIMIT,
    parameter int RIGHT_LIMIT  = c_RIGHT_LIMIT,
    parameter int WIN_SCORE    = c_WIN_SCORE,
    parameter int SPEED_SHIFT  = 5,
    parameter int SERVE_FRAMES = 60
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_tick,
    input  logic                   start,
    input  logic                   dir,
    input  logic [7:0]             speed,
    output logic [X_WIDTH-1:0]     ball_x,
    output logic [SCORE_WIDTH-1:0] left_score,
    output logic [SCORE_WIDTH-1:0] right_score,
    output logic [2:0]             state,
    output logic                   winner_valid,
    output logic                   winner_right,
    output logic                   point_pulse
);

    localparam logic [X_WIDTH-1:0]     c_CENTER     = X_WIDTH'(CENTER_X);
    localparam logic [X_WIDTH-1:0]     c_LEFT       = X_WIDTH'(LEFT_LIMIT);
    localparam logic [X_WIDTH-1:0]     c_RIGHT      = X_WIDTH'(RIGHT_LIMIT);
    localparam logic [X_WIDTH-1:0]     c_X_MAX      = {X_WIDTH{1'b1}};
    localparam logic [SCORE_WIDTH-1:0] c_WIN        = SCORE_WIDTH'(WIN_SCORE);
    localparam logic [SCORE_WIDTH-1:0] c_SCORE_ONE  = SCORE_WIDTH'(1);
    localparam logic [SCORE_WIDTH-1:0] c_SCORE_ZERO = '0;
    localparam logic [7:0]             c_SERVE_LOAD = 8'(SERVE_FRAMES);

    pong_state_e              r_state, w_stateNext;
    logic [X_WIDTH-1:0]       r_ballX, w_ballNext;
    logic [SCORE_WIDTH-1:0]   r_leftScore, w_leftNext;
    logic [SCORE_WIDTH-1:0]   r_rightScore, w_rightNext;
    logic                     r_winnerValid;
    logic                     r_winnerRight, w_winnerRightNext;
    logic                     r_pointPulse, w_pulseNext;
    logic                     r_startPrev;
    logic                     w_load;
    logic                     w_serveDone;

    logic [8:0]               w_speedShifted;
    logic [X_WIDTH-1:0]       w_step;
    logic [X_WIDTH:0]         w_sum;
    logic [X_WIDTH-1:0]       w_nx;

    frame_countdown u_serve_countdown (
        .clk       (clk),
        .reset     (reset),
        .tick      (frame_tick && (r_state == SERVE)),
        .load      (w_load),
        .loadValue (c_SERVE_LOAD),
        .done      (w_serveDone)
    );

    // Candidate position with saturation at both ends of the coordinate range.
    always_comb begin
        w_speedShifted = {1'b0, speed} >> SPEED_SHIFT;
        w_step         = X_WIDTH'(w_speedShifted);
        w_sum          = {1'b0, r_ballX} + {1'b0, w_step};
        w_nx           = r_ballX;
        if (dir) begin
            w_nx = (w_step > r_ballX) ? '0 : (r_ballX - w_step);
        end else begin
            w_nx = w_sum[X_WIDTH] ? c_X_MAX : w_sum[X_WIDTH-1:0];
        end
    end

    always_comb begin
        w_stateNext       = r_state;
        w_ballNext        = r_ballX;
        w_leftNext        = r_leftScore;
        w_rightNext       = r_rightScore;
        w_winnerRightNext = r_winnerRight;
        w_pulseNext       = 1'b0;
        w_load            = 1'b0;
        if (frame_tick) begin
            case (r_state)
                IDLE: begin
                    w_ballNext  = c_CENTER;
                    w_leftNext  = c_SCORE_ZERO;
                    w_rightNext = c_SCORE_ZERO;
                    if (start) begin
                        w_stateNext = SERVE;
                        w_load      = 1'b1;
                    end
                end
                SERVE: begin
                    w_ballNext = c_CENTER;
                    if (w_serveDone) begin
                        w_stateNext = PLAY;
                    end
                end
                PLAY: begin
                    if (w_nx < c_LEFT) begin
                        w_rightNext = r_rightScore + c_SCORE_ONE;
                        w_ballNext  = c_CENTER;
                        w_pulseNext = 1'b1;
                        w_stateNext = POINT;
                    end else if (w_nx > c_RIGHT) begin
                        w_leftNext  = r_leftScore + c_SCORE_ONE;
                        w_ballNext  = c_CENTER;
                        w_pulseNext = 1'b1;
                        w_stateNext = POINT;
                    end else begin
                        w_ballNext = w_nx;
                    end
                end
                POINT: begin
                    if ((r_leftScore == c_WIN) || (r_rightScore == c_WIN)) begin
                        w_stateNext       = GAMEOVER;
                        w_winnerRightNext = (r_rightScore == c_WIN);
                    end else begin
                        w_stateNext = SERVE;
                        w_load      = 1'b1;
                    end
                end
                GAMEOVER: begin
                    if (start && !r_startPrev) begin
                        w_leftNext  = c_SCORE_ZERO;
                        w_rightNext = c_SCORE_ZERO;
                        w_stateNext = SERVE;
                        w_load      = 1'b1;
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                end
            endcase

            // Dropping start mid-match wins over any move or score on this tick.
            if (!start && ((r_state == SERVE) || (r_state == PLAY) || (r_state == POINT))) begin
                w_stateNext = IDLE;
                w_ballNext  = c_CENTER;
                w_leftNext  = c_SCORE_ZERO;
                w_rightNext = c_SCORE_ZERO;
                w_pulseNext = 1'b0;
                w_load      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_ballX       <= c_CENTER;
            r_leftScore   <= c_SCORE_ZERO;
            r_rightScore  <= c_SCORE_ZERO;
            r_winnerValid <= 1'b0;
            r_winnerRight <= 1'b0;
            r_pointPulse  <= 1'b0;
            r_startPrev   <= 1'b0;
        end else begin
            r_state       <= w_stateNext;
            r_ballX       <= w_ballNext;
            r_leftScore   <= w_leftNext;
            r_rightScore  <= w_rightNext;
            r_winnerValid <= (w_stateNext == GAMEOVER);
            r_winnerRight <= w_winnerRightNext;
            r_pointPulse  <= w_pulseNext;
            if (frame_tick) begin
                r_startPrev <= start;
            end
        end
    end

    assign ball_x       = r_ballX;
    assign left_score   = r_leftScore;
    assign right_score  = r_rightScore;
    assign state        = r_state;
    assign winner_valid = r_winnerValid;
    assign winner_right = r_winnerRight;
    assign point_pulse  = r_pointPulse;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pong_game_engine: scoreboard bench for pong_game_engine            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_pong_game_engine;

    localparam int c_SF = 2;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       start;
    logic       dir;
    logic [7:0] speed;
    logic [9:0] ball_x;
    logic [7:0] left_score;
    logic [7:0] right_score;
    logic [2:0] state;
    logic       winner_valid;
    logic       winner_right;
    logic       point_pulse;

    pong_game_engine #(.SERVE_FRAMES(c_SF)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .start        (start),
        .dir          (dir),
        .speed        (speed),
        .ball_x       (ball_x),
        .left_score   (left_score),
        .right_score  (right_score),
        .state        (state),
        .winner_valid (winner_valid),
        .winner_right (winner_right),
        .point_pulse  (point_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ball;
        int left;
        int right;
        int st;
        int wv;
        int wr;
        int pp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model of the game state.
    int m_state, m_ball, m_left, m_right, m_wr, m_pp, m_cnt, m_prev;

    task automatic check_value(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_ball = 285; m_left = 0; m_right = 0;
        m_wr = 0; m_pp = 0; m_cnt = 0; m_prev = 0;
    endtask

    task automatic model_abort();
        m_state = 0; m_ball = 285; m_left = 0; m_right = 0;
    endtask

    task automatic model_tick(input int st, input int d, input int sp);
        int step, nx;
        m_pp = 0;
        case (m_state)
            0: begin
                m_ball = 285; m_left = 0; m_right = 0;
                if (st != 0) begin m_state = 1; m_cnt = c_SF; end
            end
            1: begin
                if (st == 0) model_abort();
                else begin
                    m_cnt--;
                    if (m_cnt == 0) m_state = 2;
                end
            end
            2: begin
                if (st == 0) model_abort();
                else begin
                    step = sp / 32;
                    if (d != 0) nx = (m_ball - step < 0) ? 0 : m_ball - step;
                    else        nx = (m_ball + step > 1023) ? 1023 : m_ball + step;
                    if (nx < 160) begin
                        m_right++; m_ball = 285; m_pp = 1; m_state = 3;
                    end else if (nx > 430) begin
                        m_left++; m_ball = 285; m_pp = 1; m_state = 3;
                    end else begin
                        m_ball = nx;
                    end
                end
            end
            3: begin
                if (st == 0) model_abort();
                else if (m_left == 5 || m_right == 5) begin
                    m_state = 4; m_wr = (m_right == 5) ? 1 : 0;
                end else begin
                    m_state = 1; m_cnt = c_SF;
                end
            end
            default: begin
                if (st != 0 && m_prev == 0) begin
                    m_left = 0; m_right = 0; m_state = 1; m_cnt = c_SF;
                end
            end
        endcase
        m_prev = st;
    endtask

    task automatic push_expected();
        exp_t e;
        e.ball = m_ball; e.left = m_left; e.right = m_right; e.st = m_state;
        e.wv = (m_state == 4) ? 1 : 0; e.wr = m_wr; e.pp = m_pp;
        exp_q.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_value("queue_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            check_value("ball_x", int'(ball_x), e.ball);
            check_value("left_score", int'(left_score), e.left);
            check_value("right_score", int'(right_score), e.right);
            check_value("state", int'(state), e.st);
            check_value("winner_valid", int'(winner_valid), e.wv);
            check_value("winner_right", int'(winner_right), e.wr);
            check_value("point_pulse", int'(point_pulse), e.pp);
        end
    endtask

    // One frame: tick cycle, then a quiet cycle where nothing may change.
    task automatic do_frame(input int st, input int d, input int sp);
        @(negedge clk);
        start = (st != 0); dir = (d != 0); speed = 8'(sp); frame_tick = 1'b1;
        model_tick(st, d, sp);
        push_expected();
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        pop_compare();
        @(posedge clk);
        #1;
        check_value("pulse_low", int'(point_pulse), 0);
        check_value("hold_state", int'(state), m_state);
    endtask

    task automatic run_until(input int st, input int d, input int sp, input int target, input int max);
        for (int i = 0; i < max && m_state != target; i++) do_frame(st, d, sp);
        check_value("reach_state", int'(state), target);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        push_expected();
        @(posedge clk);
        #1;
        pop_compare();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; frame_tick = 1'b0; start = 1'b0; dir = 1'b0; speed = 8'd0;
        model_reset();
        repeat (2) @(posedge clk);
        apply_reset();

        // Basic serve and play
        do_frame(1, 0, 64);
        check_value("serve_enter", int'(state), 1);
        do_frame(1, 0, 64);
        do_frame(1, 0, 64);
        check_value("play_enter", int'(state), 2);
        do_frame(1, 0, 64);
        check_value("ball_287", int'(ball_x), 287);
        do_frame(1, 0, 64);
        check_value("ball_289", int'(ball_x), 289);

        // Left limit scoring
        run_until(1, 1, 255, 3, 60);
        check_value("right_pt", int'(right_score), 1);
        check_value("ball_center", int'(ball_x), 285);
        do_frame(1, 1, 255);
        check_value("point_to_serve", int'(state), 1);

        // Exact right limit, then zero step, then one past
        run_until(1, 0, 160, 2, 5);
        repeat (29) do_frame(1, 0, 160);
        check_value("ball_430", int'(ball_x), 430);
        do_frame(1, 0, 31);
        check_value("step0_hold", int'(ball_x), 430);
        do_frame(1, 0, 32);
        check_value("left_pt", int'(left_score), 1);

        // Left player wins
        for (int i = 0; i < 400 && m_state != 4; i++) do_frame(1, 0, 255);
        check_value("gameover", int'(state), 4);
        check_value("win_valid", int'(winner_valid), 1);
        check_value("win_right", int'(winner_right), 0);
        check_value("win_left5", int'(left_score), 5);
        repeat (3) do_frame(1, 0, 255);
        check_value("no_restart", int'(state), 4);
        do_frame(0, 0, 255);
        check_value("go_start_low", int'(state), 4);
        do_frame(1, 0, 255);
        check_value("restart_serve", int'(state), 1);
        check_value("restart_left", int'(left_score), 0);

        // Abort on a scoring tick
        run_until(1, 0, 255, 3, 60);
        run_until(1, 0, 255, 2, 10);
        for (int i = 0; i < 60 && m_ball + 7 <= 430; i++) do_frame(1, 0, 255);
        do_frame(0, 0, 255);
        check_value("abort_idle", int'(state), 0);
        check_value("abort_left", int'(left_score), 0);

        // Reset in the middle of play
        for (int i = 0; i < 400 && m_left != 3; i++) do_frame(1, 0, 255);
        run_until(1, 1, 160, 2, 10);
        repeat (17) do_frame(1, 1, 160);
        check_value("pre_rst_ball", int'(ball_x), 200);
        check_value("pre_rst_left", int'(left_score), 3);
        apply_reset();
        check_value("rst_state", int'(state), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1);
    end

endmodule
`default_nettype wire
